// File: rtl/arc4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arc4_pkg
// Brief    : Shared ARC4 constants, state encodings and key-byte select.
// Revision : 1.0
// ============================================================================
package arc4_pkg;

   localparam int KEY_BYTES = 3;
   localparam int MEM_DEPTH = 256;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_INIT,
      ST_KSA_RD_SI,
      ST_KSA_WAIT_SI,
      ST_KSA_RD_SJ,
      ST_KSA_WAIT_SJ,
      ST_KSA_WR_SI,
      ST_KSA_WR_SJ,
      ST_LEN_RD,
      ST_LEN_WR,
      ST_PRGA_REQ,
      ST_PRGA_WAIT,
      ST_DONE
   } enc_state_t;

   typedef enum logic [3:0] {
      PG_IDLE,
      PG_RD_SI,
      PG_WAIT_SI,
      PG_RD_SJ,
      PG_WAIT_SJ,
      PG_WR_SI,
      PG_WR_SJ,
      PG_RD_PAD,
      PG_WAIT_PAD
   } prga_state_t;

   // Key byte 0 is the most significant byte of the 24-bit key.
   function automatic logic [7:0] key_byte(input logic [23:0] key, input logic [1:0] sel);
      case (sel)
         2'd0:    key_byte = key[23:16];
         2'd1:    key_byte = key[15:8];
         default: key_byte = key[7:0];
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/arc4_prga.sv
`default_nettype none
// ============================================================================
// Module   : arc4_prga
// Brief    : ARC4 keystream generator; one pad byte per req over the S port.
// Revision : 1.0
// ============================================================================
module arc4_prga
   import arc4_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       req,
   output logic [7:0] s_addr,
   output logic [7:0] s_wrdata,
   output logic       s_wren,
   input  logic [7:0] s_rddata,
   output logic [7:0] pad,
   output logic       pad_valid
);

   prga_state_t r_state, w_next;
   logic [7:0]  r_i, r_j, r_si, r_sj;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= PG_IDLE;
         r_i     <= 8'd0;
         r_j     <= 8'd0;
         r_si    <= 8'd0;
         r_sj    <= 8'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            PG_IDLE:    if (req) r_i <= r_i + 8'd1;
            PG_WAIT_SI: begin
               r_si <= s_rddata;
               r_j  <= r_j + s_rddata;
            end
            PG_WAIT_SJ: r_sj <= s_rddata;
            default: ;
         endcase
         if (clr) begin
            r_i <= 8'd0;
            r_j <= 8'd0;
         end
      end
   end

   always_comb begin
      w_next    = r_state;
      s_addr    = 8'd0;
      s_wrdata  = 8'd0;
      s_wren    = 1'b0;
      pad       = 8'd0;
      pad_valid = 1'b0;
      case (r_state)
         PG_IDLE:    if (req) w_next = PG_RD_SI;
         PG_RD_SI:   begin s_addr = r_i; w_next = PG_WAIT_SI; end
         PG_WAIT_SI: w_next = PG_RD_SJ;
         PG_RD_SJ:   begin s_addr = r_j; w_next = PG_WAIT_SJ; end
         PG_WAIT_SJ: w_next = PG_WR_SI;
         PG_WR_SI:   begin s_addr = r_i; s_wrdata = r_sj; s_wren = 1'b1; w_next = PG_WR_SJ; end
         PG_WR_SJ:   begin s_addr = r_j; s_wrdata = r_si; s_wren = 1'b1; w_next = PG_RD_PAD; end
         PG_RD_PAD:  begin s_addr = r_si + r_sj; w_next = PG_WAIT_PAD; end
         PG_WAIT_PAD: begin
            pad       = s_rddata;
            pad_valid = 1'b1;
            w_next    = PG_IDLE;
         end
         default:    w_next = PG_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/arc4_encrypt.sv
`default_nettype none
// ============================================================================
// Module   : arc4_encrypt
// Brief    : ARC4 encryptor: S init, KSA, then length-prefixed pt -> ct.
// Revision : 1.0
// ============================================================================
module arc4_encrypt
   import arc4_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   output logic        rdy,
   input  logic [23:0] key,
   output logic [7:0]  pt_addr,
   input  logic [7:0]  pt_rddata,
   output logic [7:0]  ct_addr,
   output logic [7:0]  ct_wrdata,
   output logic        ct_wren,
   output logic [7:0]  s_addr,
   input  logic [7:0]  s_rddata,
   output logic [7:0]  s_wrdata,
   output logic        s_wren
);

   enc_state_t  r_state, w_next;
   logic [23:0] r_key;
   logic [8:0]  r_i;
   logic [8:0]  w_i_next;
   logic [7:0]  r_j, r_si, r_sj, r_len, r_k;
   logic [1:0]  r_kidx;

   logic        w_pg_clr, w_pg_req, w_pg_wren, w_pg_valid;
   logic [7:0]  w_pg_addr, w_pg_wrdata, w_pg_pad;

   assign w_i_next = r_i + 9'd1;

   arc4_prga u_prga (
      .clk       (clk),
      .rst       (rst),
      .clr       (w_pg_clr),
      .req       (w_pg_req),
      .s_addr    (w_pg_addr),
      .s_wrdata  (w_pg_wrdata),
      .s_wren    (w_pg_wren),
      .s_rddata  (s_rddata),
      .pad       (w_pg_pad),
      .pad_valid (w_pg_valid)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_key   <= 24'd0;
         r_i     <= 9'd0;
         r_j     <= 8'd0;
         r_si    <= 8'd0;
         r_sj    <= 8'd0;
         r_kidx  <= 2'd0;
         r_len   <= 8'd0;
         r_k     <= 8'd0;
      end else begin
         r_state <= w_next;
         case (r_state)
            ST_IDLE: if (en) begin
               r_key <= key;
               r_i   <= 9'd0;
            end
            ST_INIT: begin
               if (r_i == 9'(MEM_DEPTH - 1)) begin
                  r_i    <= 9'd0;
                  r_j    <= 8'd0;
                  r_kidx <= 2'd0;
               end else begin
                  r_i <= w_i_next;
               end
            end
            ST_KSA_WAIT_SI: begin
               r_si <= s_rddata;
               r_j  <= r_j + s_rddata + key_byte(r_key, r_kidx);
            end
            ST_KSA_WAIT_SJ: r_sj <= s_rddata;
            ST_KSA_WR_SJ: begin
               r_i    <= w_i_next;
               r_kidx <= (r_kidx == 2'(KEY_BYTES - 1)) ? 2'd0 : r_kidx + 2'd1;
            end
            ST_LEN_WR: begin
               r_len <= pt_rddata;
               r_k   <= 8'd1;
            end
            ST_PRGA_WAIT: if (w_pg_valid) r_k <= r_k + 8'd1;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next    = r_state;
      rdy       = 1'b0;
      pt_addr   = 8'd0;
      ct_addr   = 8'd0;
      ct_wrdata = 8'd0;
      ct_wren   = 1'b0;
      s_addr    = 8'd0;
      s_wrdata  = 8'd0;
      s_wren    = 1'b0;
      w_pg_clr  = 1'b0;
      w_pg_req  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            rdy = 1'b1;
            if (en) w_next = ST_INIT;
         end
         ST_INIT: begin
            s_addr   = r_i[7:0];
            s_wrdata = r_i[7:0];
            s_wren   = 1'b1;
            if (r_i == 9'(MEM_DEPTH - 1)) w_next = ST_KSA_RD_SI;
         end
         ST_KSA_RD_SI:   begin s_addr = r_i[7:0]; w_next = ST_KSA_WAIT_SI; end
         ST_KSA_WAIT_SI: w_next = ST_KSA_RD_SJ;
         ST_KSA_RD_SJ:   begin s_addr = r_j; w_next = ST_KSA_WAIT_SJ; end
         ST_KSA_WAIT_SJ: w_next = ST_KSA_WR_SI;
         ST_KSA_WR_SI: begin
            s_addr = r_i[7:0]; s_wrdata = r_sj; s_wren = 1'b1;
            w_next = ST_KSA_WR_SJ;
         end
         ST_KSA_WR_SJ: begin
            s_addr = r_j; s_wrdata = r_si; s_wren = 1'b1;
            w_next = w_i_next[8] ? ST_LEN_RD : ST_KSA_RD_SI;
         end
         ST_LEN_RD: w_next = ST_LEN_WR;
         ST_LEN_WR: begin
            ct_wrdata = pt_rddata;
            ct_wren   = 1'b1;
            w_pg_clr  = 1'b1;
            w_next    = (pt_rddata == 8'd0) ? ST_DONE : ST_PRGA_REQ;
         end
         // pt[k] address is held across the whole keystream fetch.
         ST_PRGA_REQ, ST_PRGA_WAIT: begin
            pt_addr  = r_k;
            s_addr   = w_pg_addr;
            s_wrdata = w_pg_wrdata;
            s_wren   = w_pg_wren;
            if (r_state == ST_PRGA_REQ) begin
               w_pg_req = 1'b1;
               w_next   = ST_PRGA_WAIT;
            end else if (w_pg_valid) begin
               ct_addr   = r_k;
               ct_wrdata = pt_rddata ^ w_pg_pad;
               ct_wren   = 1'b1;
               w_next    = (r_k == r_len) ? ST_DONE : ST_PRGA_REQ;
            end
         end
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_arc4_encrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_arc4_encrypt
// Brief    : Directed-vector bench for arc4_encrypt with behavioural memories.
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_arc4_encrypt;

   logic        clk = 1'b0;
   logic        rst, en, rdy;
   logic [23:0] key;
   logic [7:0]  pt_addr, pt_rddata, ct_addr, ct_wrdata, s_addr, s_rddata, s_wrdata;
   logic        ct_wren, s_wren;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   arc4_encrypt dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .rdy       (rdy),
      .key       (key),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .ct_addr   (ct_addr),
      .ct_wrdata (ct_wrdata),
      .ct_wren   (ct_wren),
      .s_addr    (s_addr),
      .s_rddata  (s_rddata),
      .s_wrdata  (s_wrdata),
      .s_wren    (s_wren)
   );

   logic [7:0] s_mem  [256];
   logic [7:0] pt_mem [256];
   logic [7:0] ct_mem [256];
   logic [7:0] ks_ref [256];
   logic       log_clr = 1'b0;
   int         ct_wr_cnt, ct_last_addr, ct_max_addr;

   always @(posedge clk) begin
      if (s_wren) s_mem[s_addr] <= s_wrdata;
      s_rddata  <= s_mem[s_addr];
      pt_rddata <= pt_mem[pt_addr];
      if (log_clr) begin
         for (int n = 0; n < 256; n++) ct_mem[n] <= 8'hEE;
         ct_wr_cnt    <= 0;
         ct_last_addr <= -1;
         ct_max_addr  <= -1;
      end else if (ct_wren) begin
         ct_mem[ct_addr] <= ct_wrdata;
         ct_wr_cnt       <= ct_wr_cnt + 1;
         ct_last_addr    <= int'(ct_addr);
         if (int'(ct_addr) > ct_max_addr) ct_max_addr <= int'(ct_addr);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Software ARC4 reference keystream, bytes 1..255.
   task automatic ref_ks(input logic [23:0] k);
      logic [7:0] s[256];
      logic [7:0] kb[3];
      logic [7:0] i, j, t;
      kb[0] = k[23:16]; kb[1] = k[15:8]; kb[2] = k[7:0];
      for (int n = 0; n < 256; n++) s[n] = 8'(n);
      j = 8'd0;
      for (int n = 0; n < 256; n++) begin
         j = j + s[n] + kb[n % 3];
         t = s[n]; s[n] = s[j]; s[j] = t;
      end
      i = 8'd0; j = 8'd0; ks_ref[0] = 8'd0;
      for (int n = 1; n < 256; n++) begin
         i = i + 8'd1;
         j = j + s[i];
         t = s[i]; s[i] = s[j]; s[j] = t;
         ks_ref[n] = s[8'(s[i] + s[j])];
      end
   endtask

   task automatic clear_log();
      @(negedge clk); log_clr = 1'b1;
      @(negedge clk); log_clr = 1'b0;
   endtask

   task automatic start_run(input logic [23:0] k);
      @(negedge clk); key = k; en = 1'b1;
      @(negedge clk); en = 1'b0; key = 24'd0;
   endtask

   task automatic wait_rdy(input string tag);
      int n = 0;
      while (rdy !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      check_val(tag, 32'(rdy), 32'd1);
   endtask

   task automatic load_pt(input string str);
      pt_mem[0] = 8'(str.len());
      for (int n = 0; n < str.len(); n++) pt_mem[n + 1] = str[n];
   endtask

   logic [7:0] v1_ct [10] = '{8'h09, 8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

   task automatic check_v1(input string tag);
      int bad = 0;
      for (int n = 0; n < 10; n++) if (ct_mem[n] !== v1_ct[n]) bad++;
      check_val({tag, "_bytes_bad"}, 32'(bad), 32'd0);
      check_val({tag, "_wr_cnt"}, 32'(ct_wr_cnt), 32'd10);
      check_val({tag, "_last_addr"}, 32'(ct_last_addr), 32'd9);
      check_val({tag, "_beyond_len"}, 32'(ct_mem[10]), 32'hEE);
   endtask

   initial begin
      int bad;
      rst = 1'b1; en = 1'b0; key = 24'd0;
      for (int n = 0; n < 256; n++) pt_mem[n] = 8'd0;
      repeat (2) @(negedge clk);
      check_val("rst_rdy", 32'(rdy), 32'd1);
      check_val("rst_s_wren", 32'(s_wren), 32'd0);
      check_val("rst_ct_wren", 32'(ct_wren), 32'd0);
      check_val("rst_s_addr", 32'(s_addr), 32'd0);
      rst = 1'b0;

      // Vector 1: "Key" / "Plaintext"
      load_pt("Plaintext");
      clear_log();
      start_run(24'h4B6579);
      check_val("v1_rdy_drop", 32'(rdy), 32'd0);
      wait_rdy("v1_done");
      check_v1("v1");

      // len = 0
      pt_mem[0] = 8'd0;
      clear_log();
      start_run(24'h000000);
      wait_rdy("len0_done");
      check_val("len0_ct0", 32'(ct_mem[0]), 32'd0);
      check_val("len0_wr_cnt", 32'(ct_wr_cnt), 32'd1);
      check_val("len0_max_addr", 32'(ct_max_addr), 32'd0);

      // len = 255 against the reference keystream
      pt_mem[0] = 8'd255;
      for (int n = 1; n < 256; n++) pt_mem[n] = 8'($urandom_range(0, 255));
      ref_ks(24'h123456);
      clear_log();
      start_run(24'h123456);
      wait_rdy("len255_done");
      bad = 0;
      for (int n = 1; n < 256; n++) if ((ct_mem[n] ^ pt_mem[n]) !== ks_ref[n]) bad++;
      check_val("len255_bytes_bad", 32'(bad), 32'd0);
      check_val("len255_ct0", 32'(ct_mem[0]), 32'd255);
      check_val("len255_wr_cnt", 32'(ct_wr_cnt), 32'd256);
      check_val("len255_last_addr", 32'(ct_last_addr), 32'd255);

      // Reset mid-KSA, then rerun vector 1
      load_pt("Plaintext");
      start_run(24'h123456);
      repeat (860) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("midrst_rdy", 32'(rdy), 32'd1);
      check_val("midrst_s_wren", 32'(s_wren), 32'd0);
      check_val("midrst_ct_wren", 32'(ct_wren), 32'd0);
      check_val("midrst_s_addr", 32'(s_addr), 32'd0);
      check_val("midrst_s_wrdata", 32'(s_wrdata), 32'd0);
      rst = 1'b0;
      clear_log();
      start_run(24'h4B6579);
      wait_rdy("rerun_done");
      check_v1("rerun");

      // en held 3 cycles with changing key, plus a pulse while busy
      clear_log();
      @(negedge clk); key = 24'h4B6579; en = 1'b1;
      @(negedge clk); key = 24'hAAAAAA;
      check_val("hold_rdy_drop", 32'(rdy), 32'd0);
      @(negedge clk); key = 24'h555555;
      @(negedge clk); en = 1'b0; key = 24'd0;
      repeat (500) @(negedge clk);
      en = 1'b1; key = 24'h111111;
      @(negedge clk); en = 1'b0; key = 24'd0;
      wait_rdy("hold_done");
      repeat (20) @(negedge clk);
      check_val("hold_idle_rdy", 32'(rdy), 32'd1);
      check_v1("hold");

      // Round trip {5,"hello"} with key 000001
      load_pt("hello");
      ref_ks(24'h000001);
      clear_log();
      start_run(24'h000001);
      wait_rdy("rt_done");
      check_val("rt_ct0", 32'(ct_mem[0]), 32'd5);
      bad = 0;
      for (int n = 1; n <= 5; n++) if ((ct_mem[n] ^ ks_ref[n]) !== pt_mem[n]) bad++;
      check_val("rt_decrypt_bad", 32'(bad), 32'd0);
      check_val("rt_wr_cnt", 32'(ct_wr_cnt), 32'd6);
      check_val("rt_beyond_len", 32'(ct_mem[6]), 32'hEE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
